alu_shift_mem: RTL and testbench
================================

ALU_SHIFT_MEM -- requirements
Module: alu_shift_mem

Interface
REQ-001 Parameters: none; data width fixed at 8 bits, memory depth fixed at 256 words.
REQ-002 clk  input  1  rising-edge clock for flag registers and memory writes.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 alu_op  input  3  ALU operation select.
REQ-005 alu_a, alu_b  input  8 each  ALU operands.
REQ-006 alu_use_carry  input  1  1: ALU carry-in = c_flag; 0: carry-in = 0.
REQ-007 sh_data  input  8  shifter operand.
REQ-008 sh_count  input  3  shift/rotate amount, 0..7.
REQ-009 sh_dir  input  1  0 = left, 1 = right.
REQ-010 sh_shift  input  1  1 = logical shift, 0 = rotate.
REQ-011 select_c, select_z  input  1 each  flag source: 0 = ALU, 1 = shifter.
REQ-012 write_c, write_z  input  1 each  flag update enables.
REQ-013 mem_we  input  1  memory write enable.
REQ-014 mem_addr, mem_wdata  input  8 each  memory address, write data.
REQ-015 alu_out  output  8  ALU result.
REQ-016 alu_co, alu_z  output  1 each  ALU carry/borrow, ALU zero.
REQ-017 sh_out  output  8  shifter result.
REQ-018 sh_c, sh_z  output  1 each  shifter carry, shifter zero.
REQ-019 mem_rdata  output  8  memory read data.
REQ-020 c_flag, z_flag  output  1 each  registered carry and zero flags.

Function
REQ-021 ALU is combinational; cin = alu_use_carry & c_flag.
REQ-022 000 ADD: {alu_co,alu_out} = a + b + cin, 9-bit sum.
REQ-023 001 SUB: alu_out = a - b - cin mod 256; alu_co = 1 iff a < b + cin (borrow).
REQ-024 ops 010 AND, 011 OR, 100 XOR, 101 NOT a, 110 pass b, 111 pass a; alu_co = 0 for all six.
REQ-025 alu_z = 1 iff alu_out == 0, for every op.
REQ-026 Shifter is combinational; logical shift fills with zeros; rotate wraps bits around.
REQ-027 sh_count = 0: sh_out = sh_data, sh_c = 0.
REQ-028 Shift, sh_count = n > 0: sh_c = last bit shifted out, i.e. sh_data[8-n] for left, sh_data[n-1] for right.
REQ-029 Rotate, sh_count = n > 0: sh_c = sh_out[0] for left, sh_out[7] for right.
REQ-030 sh_z = 1 iff sh_out == 0.
REQ-031 Memory is 256x8; asynchronous (combinational) read: mem_rdata = mem[mem_addr] at all times.
REQ-032 Write occurs on rising clk when mem_we = 1; mem_rdata reflects the new value after that edge.
REQ-033 Read-during-write to the same address returns old data until the edge.
REQ-034 On rising clk: if write_c, c_flag <= (select_c ? sh_c : alu_co); if write_z, z_flag <= (select_z ? sh_z : alu_z); otherwise each flag holds.
REQ-035 ADC chaining: c_flag written in cycle k is used as cin in cycle k+1 when alu_use_carry = 1.

Reset
REQ-036 While reset = 1: c_flag = 0, z_flag = 0, all memory words = 0; writes and flag updates are ignored.
REQ-037 Reset asserted mid-operation takes effect immediately, without waiting for a clock edge; combinational outputs follow their inputs and the cleared state.

Structure
REQ-038 A shared package holds the ALU opcode constants (ALU_ADD..ALU_PASSA) and the width constants DATA_W = 8, MEM_DEPTH = 256.
REQ-039 Sub-module barrel_shifter8 implements REQ-026..030; ALU, memory and flags stay in the top module.

Verification
REQ-040 ADD: a = 0xFF, b = 0x01, use_carry = 0 -> alu_out = 0x00, co = 1, z = 1; with write_c = write_z = 1, after the edge c_flag = 1, z_flag = 1.
REQ-041 ADC: c_flag = 1, use_carry = 1, ADD a = 0x10, b = 0x20 -> alu_out = 0x31, co = 0.
REQ-042 SUB: a = 0x05, b = 0x07, cin = 0 -> alu_out = 0xFE, co = 1, z = 0.
REQ-043 Shifter: sh_data = 0x81, count = 1: shift left -> 0x02, c = 1; rotate right -> 0xC0, c = 1; shift right count 7 -> 0x01, c = 0; shift left count 0 -> 0x81, c = 0.
REQ-044 Memory: write 0xA5 to addr 0x3C -> same-cycle read returns the old value, next cycle 0xA5; assert reset -> read 0x00 and flags 0 immediately.
REQ-045 Flag select: select_c = 1, write_c = 1, shift left 0x80 by 1 -> c_flag = 1; write_c = 0 next cycle -> c_flag holds.

Source files
------------

// File: rtl/alu_shift_mem_pkg.sv
// rtl/alu_shift_mem_pkg.sv - shared widths and ALU opcodes for alu_shift_mem
package alu_shift_mem_pkg;

  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 256;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_XOR   = 3'b100,
    ALU_NOT   = 3'b101,
    ALU_PASSB = 3'b110,
    ALU_PASSA = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_shift_mem_shifter.sv
// rtl/alu_shift_mem_shifter.sv - combinational 8-bit barrel shifter/rotator with carry and zero
module barrel_shifter8
  import alu_shift_mem_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [2:0]        count_i,
  input  logic              dir_i,
  input  logic              shift_i,
  output logic [DATA_W-1:0] out_o,
  output logic              c_o,
  output logic              z_o
);

  logic [DATA_W:0]   left9;
  logic [DATA_W:0]   right9;
  logic [DATA_W-1:0] rol;
  logic [DATA_W-1:0] ror;
  logic [3:0]        inv_count;

  // The extra bit on each side catches the last bit pushed out.
  assign left9     = {1'b0, data_i} << count_i;
  assign right9    = {data_i, 1'b0} >> count_i;
  assign inv_count = 4'd8 - {1'b0, count_i};
  assign rol       = (data_i << count_i) | (data_i >> inv_count);
  assign ror       = (data_i >> count_i) | (data_i << inv_count);

  always_comb begin
    out_o = data_i;
    c_o   = 1'b0;
    if (count_i != 3'd0) begin
      unique case ({shift_i, dir_i})
        2'b10: begin out_o = left9[DATA_W-1:0]; c_o = left9[DATA_W]; end
        2'b11: begin out_o = right9[DATA_W:1];  c_o = right9[0];     end
        2'b00: begin out_o = rol;               c_o = rol[0];        end
        default: begin out_o = ror;             c_o = ror[DATA_W-1]; end
      endcase
    end
  end

  assign z_o = (out_o == '0);

endmodule

// File: rtl/alu_shift_mem.sv
// rtl/alu_shift_mem.sv - 8-bit ALU, barrel shifter, 256x8 memory and carry/zero flags
module alu_shift_mem
  import alu_shift_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  input  logic              alu_use_carry,
  input  logic [DATA_W-1:0] sh_data,
  input  logic [2:0]        sh_count,
  input  logic              sh_dir,
  input  logic              sh_shift,
  input  logic              select_c,
  input  logic              select_z,
  input  logic              write_c,
  input  logic              write_z,
  input  logic              mem_we,
  input  logic [7:0]        mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] alu_out,
  output logic              alu_co,
  output logic              alu_z,
  output logic [DATA_W-1:0] sh_out,
  output logic              sh_c,
  output logic              sh_z,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              c_flag,
  output logic              z_flag
);

  logic              c_flag_q, c_flag_d;
  logic              z_flag_q, z_flag_d;
  logic              cin;
  logic [DATA_W:0]   sum9;
  logic [DATA_W:0]   diff9;
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  assign cin = alu_use_carry & c_flag_q;
  // Bit 8 of the 9-bit difference is the borrow (a < b + cin).
  assign sum9  = {1'b0, alu_a} + {1'b0, alu_b} + {{DATA_W{1'b0}}, cin};
  assign diff9 = {1'b0, alu_a} - {1'b0, alu_b} - {{DATA_W{1'b0}}, cin};

  always_comb begin
    alu_out = '0;
    alu_co  = 1'b0;
    unique case (alu_op_e'(alu_op))
      ALU_ADD:   begin alu_out = sum9[DATA_W-1:0];  alu_co = sum9[DATA_W];  end
      ALU_SUB:   begin alu_out = diff9[DATA_W-1:0]; alu_co = diff9[DATA_W]; end
      ALU_AND:   alu_out = alu_a & alu_b;
      ALU_OR:    alu_out = alu_a | alu_b;
      ALU_XOR:   alu_out = alu_a ^ alu_b;
      ALU_NOT:   alu_out = ~alu_a;
      ALU_PASSB: alu_out = alu_b;
      default:   alu_out = alu_a;
    endcase
  end

  assign alu_z = (alu_out == '0);

  barrel_shifter8 u_shifter (
    .data_i  (sh_data),
    .count_i (sh_count),
    .dir_i   (sh_dir),
    .shift_i (sh_shift),
    .out_o   (sh_out),
    .c_o     (sh_c),
    .z_o     (sh_z)
  );

  always_comb begin
    c_flag_d = c_flag_q;
    z_flag_d = z_flag_q;
    if (write_c) c_flag_d = select_c ? sh_c : alu_co;
    if (write_z) z_flag_d = select_z ? sh_z : alu_z;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_flag_q <= 1'b0;
      z_flag_q <= 1'b0;
    end else begin
      c_flag_q <= c_flag_d;
      z_flag_q <= z_flag_d;
    end
  end

  // Every word clears on reset, so the array is built from resettable flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata = mem_q[mem_addr];
  assign c_flag    = c_flag_q;
  assign z_flag    = z_flag_q;

endmodule

// File: tb/tb_alu_shift_mem.sv
// tb/tb_alu_shift_mem.sv - directed self-checking bench for alu_shift_mem
`timescale 1ns/1ps
module tb_alu_shift_mem;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b;
  logic       alu_use_carry;
  logic [7:0] sh_data;
  logic [2:0] sh_count;
  logic       sh_dir, sh_shift;
  logic       select_c, select_z, write_c, write_z;
  logic       mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] alu_out;
  logic       alu_co, alu_z;
  logic [7:0] sh_out;
  logic       sh_c, sh_z;
  logic [7:0] mem_rdata;
  logic       c_flag, z_flag;

  int checks   = 0;
  int failures = 0;

  alu_shift_mem dut (
    .clk(clk), .reset(reset), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_use_carry(alu_use_carry), .sh_data(sh_data), .sh_count(sh_count),
    .sh_dir(sh_dir), .sh_shift(sh_shift), .select_c(select_c), .select_z(select_z),
    .write_c(write_c), .write_z(write_z), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .alu_out(alu_out), .alu_co(alu_co), .alu_z(alu_z),
    .sh_out(sh_out), .sh_c(sh_c), .sh_z(sh_z), .mem_rdata(mem_rdata),
    .c_flag(c_flag), .z_flag(z_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic uc);
    alu_op = op; alu_a = a; alu_b = b; alu_use_carry = uc; #1;
  endtask

  task automatic shf(input logic [7:0] d, input logic [2:0] n, input logic dir,
                     input logic sh);
    sh_data = d; sh_count = n; sh_dir = dir; sh_shift = sh; #1;
  endtask

  task automatic step();
    @(posedge clk); @(negedge clk); #1;
  endtask

  typedef struct {
    logic [2:0] op; logic [7:0] a; logic [7:0] b; logic [7:0] res; logic co;
  } alu_vec_t;

  typedef struct {
    logic [7:0] d; logic [2:0] n; logic dir; logic sh; logic [7:0] res; logic c;
  } sh_vec_t;

  alu_vec_t lv [7];
  sh_vec_t  sv [8];

  initial begin
    lv[0] = '{3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0};
    lv[1] = '{3'b011, 8'hF0, 8'h3C, 8'hFC, 1'b0};
    lv[2] = '{3'b100, 8'hF0, 8'h3C, 8'hCC, 1'b0};
    lv[3] = '{3'b101, 8'hF0, 8'h3C, 8'h0F, 1'b0};
    lv[4] = '{3'b110, 8'hF0, 8'h3C, 8'h3C, 1'b0};
    lv[5] = '{3'b111, 8'hF0, 8'h3C, 8'hF0, 1'b0};
    lv[6] = '{3'b010, 8'h0F, 8'hF0, 8'h00, 1'b0};

    sv[0] = '{8'h81, 3'd1, 1'b0, 1'b1, 8'h02, 1'b1};
    sv[1] = '{8'h81, 3'd1, 1'b1, 1'b0, 8'hC0, 1'b1};
    sv[2] = '{8'h81, 3'd7, 1'b1, 1'b1, 8'h01, 1'b0};
    sv[3] = '{8'h81, 3'd0, 1'b0, 1'b1, 8'h81, 1'b0};
    sv[4] = '{8'h81, 3'd3, 1'b0, 1'b0, 8'h0C, 1'b0};
    sv[5] = '{8'h81, 3'd1, 1'b0, 1'b0, 8'h03, 1'b1};
    sv[6] = '{8'h81, 3'd1, 1'b1, 1'b1, 8'h40, 1'b1};
    sv[7] = '{8'h80, 3'd1, 1'b0, 1'b1, 8'h00, 1'b1};

    reset = 1'b1;
    alu_op = 3'b000; alu_a = 8'h00; alu_b = 8'h00; alu_use_carry = 1'b0;
    sh_data = 8'h00; sh_count = 3'd0; sh_dir = 1'b0; sh_shift = 1'b1;
    select_c = 1'b0; select_z = 1'b0; write_c = 1'b0; write_z = 1'b0;
    mem_we = 1'b0; mem_addr = 8'h3C; mem_wdata = 8'h00;
    step();
    check("reset_c_flag", 8'(c_flag), 8'h00);
    check("reset_z_flag", 8'(z_flag), 8'h00);
    check("reset_mem", mem_rdata, 8'h00);
    reset = 1'b0;
    step();

    // ADD overflow to zero, then latch both flags.
    write_c = 1'b1; write_z = 1'b1;
    alu(3'b000, 8'hFF, 8'h01, 1'b0);
    check("add_out", alu_out, 8'h00);
    check("add_co", 8'(alu_co), 8'h01);
    check("add_z", 8'(alu_z), 8'h01);
    step();
    check("add_c_flag", 8'(c_flag), 8'h01);
    check("add_z_flag", 8'(z_flag), 8'h01);
    write_c = 1'b0; write_z = 1'b0;

    alu(3'b000, 8'h10, 8'h20, 1'b1);
    check("adc_out", alu_out, 8'h31);
    check("adc_co", 8'(alu_co), 8'h00);
    alu(3'b000, 8'h10, 8'h20, 1'b0);
    check("add_nocarry_out", alu_out, 8'h30);
    alu(3'b001, 8'h05, 8'h05, 1'b1);
    check("sbc_out", alu_out, 8'hFF);
    check("sbc_co", 8'(alu_co), 8'h01);

    alu(3'b001, 8'h05, 8'h07, 1'b0);
    check("sub_out", alu_out, 8'hFE);
    check("sub_co", 8'(alu_co), 8'h01);
    check("sub_z", 8'(alu_z), 8'h00);
    alu(3'b001, 8'h07, 8'h05, 1'b0);
    check("sub_pos_out", alu_out, 8'h02);
    check("sub_pos_co", 8'(alu_co), 8'h00);

    foreach (lv[i]) begin
      alu(lv[i].op, lv[i].a, lv[i].b, 1'b1);
      check($sformatf("logic%0d_out", i), alu_out, lv[i].res);
      check($sformatf("logic%0d_co", i), 8'(alu_co), 8'(lv[i].co));
      check($sformatf("logic%0d_z", i), 8'(alu_z), 8'(lv[i].res == 8'h00));
    end

    foreach (sv[i]) begin
      shf(sv[i].d, sv[i].n, sv[i].dir, sv[i].sh);
      check($sformatf("sh%0d_out", i), sh_out, sv[i].res);
      check($sformatf("sh%0d_c", i), 8'(sh_c), 8'(sv[i].c));
      check($sformatf("sh%0d_z", i), 8'(sh_z), 8'(sv[i].res == 8'h00));
    end

    // Clear c_flag from the ALU, then load both flags from the shifter.
    alu(3'b000, 8'h00, 8'h00, 1'b0);
    write_c = 1'b1;
    step();
    check("clr_c_flag", 8'(c_flag), 8'h00);
    alu(3'b000, 8'h01, 8'h00, 1'b0);
    shf(8'h80, 3'd1, 1'b0, 1'b1);
    select_c = 1'b1; select_z = 1'b1; write_c = 1'b1; write_z = 1'b1;
    step();
    check("sel_c_flag", 8'(c_flag), 8'h01);
    check("sel_z_flag", 8'(z_flag), 8'h01);
    shf(8'h01, 3'd1, 1'b0, 1'b1);
    write_c = 1'b0; write_z = 1'b0;
    step();
    check("hold_c_flag", 8'(c_flag), 8'h01);
    check("hold_z_flag", 8'(z_flag), 8'h01);
    select_c = 1'b0; select_z = 1'b0;

    mem_addr = 8'h3C; mem_wdata = 8'hA5; mem_we = 1'b1; #1;
    check("mem_old", mem_rdata, 8'h00);
    step();
    check("mem_new", mem_rdata, 8'hA5);
    mem_addr = 8'h3D; mem_wdata = 8'h5A;
    step();
    mem_we = 1'b0; #1;
    check("mem_3d", mem_rdata, 8'h5A);
    mem_addr = 8'h3C; #1;
    check("mem_3c_kept", mem_rdata, 8'hA5);

    // Asynchronous reset away from any clock edge.
    @(posedge clk); #2;
    reset = 1'b1; #1;
    check("rst_mem", mem_rdata, 8'h00);
    check("rst_c_flag", 8'(c_flag), 8'h00);
    check("rst_z_flag", 8'(z_flag), 8'h00);
    alu(3'b000, 8'h12, 8'h34, 1'b0);
    check("rst_alu_comb", alu_out, 8'h46);
    mem_we = 1'b1; mem_wdata = 8'h77; write_c = 1'b1; write_z = 1'b1;
    alu(3'b000, 8'hFF, 8'h01, 1'b0);
    step();
    check("rst_mem_ignored", mem_rdata, 8'h00);
    check("rst_c_ignored", 8'(c_flag), 8'h00);
    check("rst_z_ignored", 8'(z_flag), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
